// File: rtl/pair_capture_if.sv
// Record stream from pair_capture to the logging side: one indexed response pair per window.
interface pair_capture_if #(
  parameter int OUT_SIZE = 8,
  parameter int IDX_W    = 16
);
  localparam int HW = $clog2(OUT_SIZE + 1);

  logic                rec_valid;
  logic                rec_ready;
  logic [IDX_W-1:0]    rec_idx;
  logic [OUT_SIZE-1:0] rec_out0;
  logic [OUT_SIZE-1:0] rec_out1;
  logic [HW-1:0]       rec_hd;

  modport master (
    output rec_valid, rec_idx, rec_out0, rec_out1, rec_hd,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_idx, rec_out0, rec_out1, rec_hd,
    output rec_ready
  );
endinterface

// File: rtl/pair_capture.sv
// Samples the monitored output over each two-vector window and queues {idx, out0, out1, hamming distance}.
//   state  | meaning
//   IDLE   | waiting for start; out_in on the start cycle becomes out0
//   SECOND | window open; out_in is out1, record pushed at end of cycle
module pair_capture #(
  parameter int OUT_SIZE = 8,
  parameter int IDX_W    = 16,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OUT_SIZE-1:0] out_in,
  pair_capture_if.master      rec,
  output logic                busy,
  output logic                overflow,
  output logic                proto_err
);
  localparam int HW = $clog2(OUT_SIZE + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t              state, state_nxt;
  logic                latch0, push_req, push_ok, pop, full;
  logic [OUT_SIZE-1:0] out0, diff;
  logic [HW-1:0]       hd;
  logic [IDX_W-1:0]    idx;

  logic [IDX_W-1:0]    mem_idx  [DEPTH];
  logic [OUT_SIZE-1:0] mem_out0 [DEPTH];
  logic [OUT_SIZE-1:0] mem_out1 [DEPTH];
  logic [HW-1:0]       mem_hd   [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch0    = 1'b0;
    push_req  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          latch0    = 1'b1;
          state_nxt = SECOND;
        end
      end
      SECOND: begin
        push_req  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    diff = out0 ^ out_in;
    hd   = '0;
    for (int i = 0; i < OUT_SIZE; i++) hd = hd + HW'(diff[i]);
  end

  assign busy    = (state == SECOND);
  assign full    = (count == CW'(DEPTH));
  assign pop     = rec.rec_valid && rec.rec_ready;
  // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0      <= '0;
      idx       <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (latch0) out0 <= out_in;
      if (state == SECOND) idx <= idx + IDX_W'(1);
      if (push_req && !push_ok) overflow <= 1'b1;
      if (state == SECOND && start) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_idx[i]  <= '0;
        mem_out0[i] <= '0;
        mem_out1[i] <= '0;
        mem_hd[i]   <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_idx[wr_ptr]  <= idx;
        mem_out0[wr_ptr] <= out0;
        mem_out1[wr_ptr] <= out_in;
        mem_hd[wr_ptr]   <= hd;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  assign rec.rec_valid = (count != '0);
  assign rec.rec_idx   = mem_idx[rd_ptr];
  assign rec.rec_out0  = mem_out0[rd_ptr];
  assign rec.rec_out1  = mem_out1[rd_ptr];
  assign rec.rec_hd    = mem_hd[rd_ptr];
endmodule

// File: tb/tb_pair_capture.sv
// Directed bench for pair_capture: main instance (IDX_W=16, DEPTH=4) plus a narrow-index instance for wrap.
module tb_pair_capture;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, start2 = 1'b0;
  logic [7:0] out_in = '0, out_in2 = '0;
  logic       busy, overflow, proto_err;
  logic       busy2, overflow2, proto_err2;

  int tests = 0;
  int fails = 0;

  pair_capture_if #(.OUT_SIZE(8), .IDX_W(16)) rif ();
  pair_capture_if #(.OUT_SIZE(8), .IDX_W(2))  rif2 ();

  pair_capture #(.OUT_SIZE(8), .IDX_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .out_in(out_in), .rec(rif),
    .busy(busy), .overflow(overflow), .proto_err(proto_err)
  );

  pair_capture #(.OUT_SIZE(8), .IDX_W(2), .DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .out_in(out_in2), .rec(rif2),
    .busy(busy2), .overflow(overflow2), .proto_err(proto_err2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Opens a window at the current cycle; returns in cycle t+2.
  task automatic window(input bit sel, input logic [7:0] a, input logic [7:0] b);
    if (sel) begin start2 = 1'b1; out_in2 = a; end
    else     begin start  = 1'b1; out_in  = a; end
    step();
    if (sel) begin start2 = 1'b0; out_in2 = b; end
    else     begin start  = 1'b0; out_in  = b; end
    step();
  endtask

  logic [7:0] pa [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'hFF};

  initial begin
    rif.rec_ready  = 1'b0;
    rif2.rec_ready = 1'b0;
    step();
    do_reset();

    check("rst_valid", 32'(rif.rec_valid), 32'd0);
    check("rst_idx",   32'(rif.rec_idx),   32'd0);
    check("rst_out0",  32'(rif.rec_out0),  32'd0);
    check("rst_out1",  32'(rif.rec_out1),  32'd0);
    check("rst_hd",    32'(rif.rec_hd),    32'd0);
    check("rst_busy",  32'(busy),          32'd0);
    check("rst_ovf",   32'(overflow),      32'd0);
    check("rst_perr",  32'(proto_err),     32'd0);

    // single window
    rif.rec_ready = 1'b1;
    start = 1'b1; out_in = 8'hA5;
    step();
    start = 1'b0; out_in = 8'h5A;
    check("single_busy", 32'(busy), 32'd1);
    check("single_valid_t1", 32'(rif.rec_valid), 32'd0);
    step();
    check("single_valid", 32'(rif.rec_valid), 32'd1);
    check("single_idx",   32'(rif.rec_idx),   32'd0);
    check("single_out0",  32'(rif.rec_out0),  32'hA5);
    check("single_out1",  32'(rif.rec_out1),  32'h5A);
    check("single_hd",    32'(rif.rec_hd),    32'd8);
    check("single_busy_t2", 32'(busy),        32'd0);
    step();
    check("single_valid_t3", 32'(rif.rec_valid), 32'd0);

    // overflow
    do_reset();
    rif.rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      window(1'b0, 8'h00, pa[i]);
      if (i == 3) check("ovf_before5", 32'(overflow), 32'd0);
    end
    check("ovf_flag", 32'(overflow), 32'd1);
    rif.rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_drain_valid%0d", i), 32'(rif.rec_valid), 32'd1);
      check($sformatf("ovf_drain_idx%0d", i),   32'(rif.rec_idx),   32'(i));
      check($sformatf("ovf_drain_hd%0d", i),    32'(rif.rec_hd),    32'(i + 1));
      check($sformatf("ovf_drain_out1_%0d", i), 32'(rif.rec_out1),  32'(pa[i]));
      step();
    end
    check("ovf_empty", 32'(rif.rec_valid), 32'd0);
    window(1'b0, 8'h00, 8'h00);
    check("ovf_sixth_valid", 32'(rif.rec_valid), 32'd1);
    check("ovf_sixth_idx",   32'(rif.rec_idx),   32'd5);
    check("ovf_still",       32'(overflow),      32'd1);
    step();

    // protocol error: second start one cycle after the first
    do_reset();
    rif.rec_ready = 1'b1;
    start = 1'b1; out_in = 8'h11;
    step();
    check("perr_early", 32'(proto_err), 32'd0);
    start = 1'b1; out_in = 8'h22;
    step();
    start = 1'b0; out_in = 8'h00;
    check("perr_flag",  32'(proto_err),     32'd1);
    check("perr_valid", 32'(rif.rec_valid), 32'd1);
    check("perr_idx",   32'(rif.rec_idx),   32'd0);
    check("perr_out1",  32'(rif.rec_out1),  32'h22);
    check("perr_hd",    32'(rif.rec_hd),    32'd4);
    check("perr_busy",  32'(busy),          32'd0);
    step();
    check("perr_one_rec", 32'(rif.rec_valid), 32'd0);
    step();
    check("perr_one_rec2", 32'(rif.rec_valid), 32'd0);
    window(1'b0, 8'h3C, 8'h3C);
    check("perr_next_idx", 32'(rif.rec_idx), 32'd1);
    check("perr_next_hd",  32'(rif.rec_hd),  32'd0);
    step();

    // full FIFO with pop in the push cycle
    do_reset();
    rif.rec_ready = 1'b0;
    window(1'b0, 8'h10, 8'h11);
    window(1'b0, 8'h20, 8'h22);
    window(1'b0, 8'h30, 8'h33);
    window(1'b0, 8'h40, 8'h44);
    start = 1'b1; out_in = 8'hF0;
    step();
    start = 1'b0; out_in = 8'h0F;
    rif.rec_ready = 1'b1;
    step();
    rif.rec_ready = 1'b0;
    check("full_ovf",  32'(overflow),    32'd0);
    check("full_head", 32'(rif.rec_idx), 32'd1);
    step();
    check("full_stable", 32'(rif.rec_idx), 32'd1);
    rif.rec_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check($sformatf("full_drain_valid%0d", i), 32'(rif.rec_valid), 32'd1);
      check($sformatf("full_drain_idx%0d", i),   32'(rif.rec_idx),   32'(i));
      step();
    end
    check("full_empty", 32'(rif.rec_valid), 32'd0);

    // reset in the middle of a window
    do_reset();
    rif.rec_ready = 1'b0;
    start = 1'b1; out_in = 8'h01;
    step();
    out_in = 8'h02;
    step();
    start = 1'b0;
    check("mid_pre_valid", 32'(rif.rec_valid), 32'd1);
    check("mid_pre_perr",  32'(proto_err),     32'd1);
    start = 1'b1; out_in = 8'h55;
    step();
    start = 1'b0;
    check("mid_pre_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_valid", 32'(rif.rec_valid), 32'd0);
    check("mid_busy",  32'(busy),          32'd0);
    check("mid_perr",  32'(proto_err),     32'd0);
    check("mid_ovf",   32'(overflow),      32'd0);
    check("mid_idx",   32'(rif.rec_idx),   32'd0);
    step();
    rst = 1'b0;
    rif.rec_ready = 1'b1;
    window(1'b0, 8'hAA, 8'h55);
    check("mid_after_valid", 32'(rif.rec_valid), 32'd1);
    check("mid_after_idx",   32'(rif.rec_idx),   32'd0);
    check("mid_after_hd",    32'(rif.rec_hd),    32'd8);
    step();

    // index wrap on the 2-bit instance, back-to-back windows
    do_reset();
    rif2.rec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      window(1'b1, 8'(i), ~8'(i));
      check($sformatf("wrap_valid%0d", i), 32'(rif2.rec_valid), 32'd1);
      check($sformatf("wrap_idx%0d", i),   32'(rif2.rec_idx),   32'(i % 4));
      check($sformatf("wrap_hd%0d", i),    32'(rif2.rec_hd),    32'd8);
    end
    check("wrap_ovf",  32'(overflow2),  32'd0);
    check("wrap_perr", 32'(proto_err2), 32'd0);
    step();
    check("wrap_empty", 32'(rif2.rec_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pair_capture.md
# pair_capture

Synthesizable receive-side companion to the correlation stimulus bench. It samples the DUT output across each two-vector window: the response to the first vector and the response to the second. It computes the Hamming distance between the two responses, which is the switching-power proxy used for correlation. Each window produces one indexed record, buffered in a small FIFO and drained over a valid/ready stream to the logging side.

## Interface
Parameters:
- OUT_SIZE, 8: width of the monitored DUT output.
- IDX_W, 16: width of the window index counter.
- DEPTH, 4: record FIFO depth; power of two, at least 2.

Ports:
- clk, in, 1: single clock; all logic is rising-edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle pulse; `out_in` this cycle is the first-vector response.
- out_in, in, OUT_SIZE: DUT output being monitored.
- rec_valid, out, 1: a record is presented at the FIFO head.
- rec_ready, in, 1: the consumer accepts the head record.
- rec_idx, out, IDX_W: window index of the head record.
- rec_out0, out, OUT_SIZE: first-vector response of the head record.
- rec_out1, out, OUT_SIZE: second-vector response of the head record.
- rec_hd, out, $clog2(OUT_SIZE+1): popcount(rec_out0 ^ rec_out1).
- busy, out, 1: a window is open (state SECOND).
- overflow, out, 1: sticky; a record was dropped because the FIFO was full.
- proto_err, out, 1: sticky; `start` arrived while a window was open.

## Operation
- FSM states:
  - IDLE: on start=1, latch out0 <= out_in and go to SECOND.
  - SECOND: unconditionally latch out1 from out_in and attempt a FIFO push of {idx, out0, out_in, hd}, then return to IDLE. hd is computed combinationally from out0 ^ out_in.
- The window counter `idx` increments by 1 at the end of every SECOND cycle, whether or not the push succeeded. It wraps modulo 2^IDX_W with no flag.
- Push succeeds if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - A failed push discards the record and sets `overflow`.
- Pop occurs when rec_valid && rec_ready. Head fields are registered FIFO contents and stay stable while rec_valid=1 and rec_ready=0.
- Push and pop in the same cycle:
  - If not full and not empty: occupancy is unchanged.
  - If empty: the pop cannot occur (rec_valid=0), so the push is accepted.
- start=1 while in SECOND:
  - The pulse is ignored; no new window opens.
  - `proto_err` is set.
  - The current window completes normally.
- `overflow` and `proto_err` clear only on rst.
- Reset values: state IDLE; idx 0; FIFO empty; rec_valid 0; rec_idx, rec_out0, rec_out1 and rec_hd all 0; busy 0; overflow 0; proto_err 0.
- Reset asserted mid-window abandons the window: no record is pushed, idx returns to 0, and buffered records are lost.

## Timing
- Define cycle t as the cycle in which start=1 is sampled. out0 = out_in at t; out1 = out_in at t+1.
- busy=1 during t+1.
- The record is written on the edge ending t+1.
- With the FIFO empty, rec_valid=1 from t+2. Latency from start to record is 2 cycles.
- Back-to-back windows (start at t, t+2, t+4, …) are legal and sustain one record per 2 cycles with rec_ready tied high.
- The minimum start spacing is 2 cycles; a start at t+1 is the protocol error described under Operation.
- rec_ready is not required to be held. The consumer may drop rec_ready at any time without loss.
- Sticky flags assert on the edge ending the offending cycle and are visible the next cycle.

## Test plan
- Single window:
  - Stimulus: start at t with out_in=8'hA5, then out_in=8'h5A at t+1, rec_ready=1.
  - Required: rec_valid=1 at t+2 with idx=0, out0=A5, out1=5A, hd=8; rec_valid=0 at t+3.
- Overflow:
  - Stimulus: rec_ready=0, five back-to-back windows with out_in pairs (00,01), (00,03), (00,07), (00,0F), (00,FF).
  - Required: the FIFO holds idx 0–3 with hd 1, 2, 3, 4; overflow=1 after the 5th window.
  - Then raise rec_ready: records drain in order 0–3, and a 6th window yields idx=5.
- Protocol error:
  - Stimulus: start at t and again at t+1.
  - Required: one record only, with idx 0; proto_err=1 from t+2.
  - Next clean window yields idx=1.
- Full with simultaneous pop:
  - Stimulus: fill the FIFO to DEPTH, then pulse rec_ready=1 for exactly the cycle in which a new window's push occurs.
  - Required: no drop, overflow stays 0, occupancy stays DEPTH, and the new record sits at the tail.
- Reset mid-window:
  - Stimulus: one record buffered, then start, then rst asserted during the SECOND cycle.
  - Required: outputs immediately return to their reset values (rec_valid=0, busy=0, flags 0).
  - After release, the first window yields idx=0.
- Index wrap:
  - Stimulus: IDX_W=2, six windows with rec_ready=1.
  - Required: rec_idx sequence 0, 1, 2, 3, 0, 1, with no flags set.
